// File: rtl/race_sequencer.sv
// race_sequencer
//   Game-flow controller for the player car datapath, clocked once per video
//   frame. Sequences IDLE -> COUNT (countdown) -> RACE -> CRASH / FINISH / OVER,
//   holds the car block in reset until the race starts, gates the WASD
//   keycodes into it and tracks lives and race time for the HUD.
//   Optional feature macro: PAUSE_EN (adds the PAUSE state toggled by 'P').
//
// Ports
//   frame_clk       in   1   frame clock (one posedge per frame)
//   Reset           in   1   synchronous, active-high reset
//   keycode_0       in   8   raw key slot 0
//   keycode_1       in   8   raw key slot 1
//   collision       in   1   car overlaps an obstacle this frame
//   PlayerDistance  in   16  distance counter from the car block
//   PlayerReset     out  1   registered reset for the car block
//   KeyOut_0        out  8   keycode_0 while racing, else 0
//   KeyOut_1        out  8   keycode_1 while racing, else 0
//   GameState       out  3   0 IDLE,1 COUNT,2 RACE,3 CRASH,4 FINISH,5 OVER,6 PAUSE
//   CountDigit      out  3   countdown digit, 0 outside COUNT
//   LivesLeft       out  2   remaining lives
//   RaceTime        out  16  frames spent in RACE, saturating
module race_sequencer #(
   parameter int          COUNT_FRAMES = 60,
   parameter int          COUNT_START  = 3,
   parameter logic [15:0] FINISH_DIST  = 16'd20000,
   parameter int          LIVES_INIT   = 3,
   parameter int          CRASH_FRAMES = 120
) (
   input  logic        frame_clk,
   input  logic        Reset,
   input  logic [7:0]  keycode_0,
   input  logic [7:0]  keycode_1,
   input  logic        collision,
   input  logic [15:0] PlayerDistance,
   output logic        PlayerReset,
   output logic [7:0]  KeyOut_0,
   output logic [7:0]  KeyOut_1,
   output logic [2:0]  GameState,
   output logic [2:0]  CountDigit,
   output logic [1:0]  LivesLeft,
   output logic [15:0] RaceTime
);

   localparam logic [7:0] KEY_ENTER = 8'h28;
   localparam int MAX_FRAMES = (COUNT_FRAMES > CRASH_FRAMES) ? COUNT_FRAMES : CRASH_FRAMES;
   localparam int CNT_W = $clog2(MAX_FRAMES) + 1;
   localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(COUNT_FRAMES - 1);
   localparam logic [CNT_W-1:0] CRASH_LAST = CNT_W'(CRASH_FRAMES - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_COUNT  = 3'd1,
      S_RACE   = 3'd2,
      S_CRASH  = 3'd3,
      S_FINISH = 3'd4,
      S_OVER   = 3'd5,
      S_PAUSE  = 3'd6
   } state_t;

   state_t           state, state_nx;
   // One counter serves both the countdown digit timer and the crash lockout;
   // the two are never active at the same time.
   logic [CNT_W-1:0] frame_cnt, frame_cnt_nx;
   logic [2:0]       digit_nx;
   logic [1:0]       lives_nx;
   logic [15:0]      time_nx;
   logic             enter_q;
   logic             enter_now;
   logic             start;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign enter_now = (keycode_0 == KEY_ENTER) || (keycode_1 == KEY_ENTER);
   assign start     = enter_now && !enter_q;

`ifdef PAUSE_EN
   localparam logic [7:0] KEY_P = 8'h13;
   logic p_q;
   logic p_now;
   logic p_edge;
   assign p_now  = (keycode_0 == KEY_P) || (keycode_1 == KEY_P);
   assign p_edge = p_now && !p_q;
`endif

   always_comb begin
      state_nx     = state;
      frame_cnt_nx = frame_cnt;
      digit_nx     = CountDigit;
      lives_nx     = LivesLeft;
      time_nx      = RaceTime;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nx     = S_COUNT;
               digit_nx     = 3'(COUNT_START);
               frame_cnt_nx = '0;
               lives_nx     = 2'(LIVES_INIT);
               time_nx      = '0;
            end
         end
         S_COUNT: begin
            if (frame_cnt == COUNT_LAST) begin
               frame_cnt_nx = '0;
               if (CountDigit == 3'd1) begin
                  state_nx = S_RACE;
                  digit_nx = 3'd0;
               end else begin
                  digit_nx = CountDigit - 3'd1;
               end
            end else begin
               frame_cnt_nx = frame_cnt + 1'b1;
            end
         end
         S_RACE: begin
            time_nx = sat_inc(RaceTime);
            // Crossing the line beats a same-frame collision.
            if (PlayerDistance >= FINISH_DIST) begin
               state_nx = S_FINISH;
            end else if (collision) begin
               state_nx     = S_CRASH;
               lives_nx     = (LivesLeft != 2'd0) ? LivesLeft - 2'd1 : 2'd0;
               frame_cnt_nx = '0;
            end
`ifdef PAUSE_EN
            else if (p_edge) begin
               state_nx = S_PAUSE;
            end
`endif
         end
         S_CRASH: begin
            if (frame_cnt == CRASH_LAST) begin
               frame_cnt_nx = '0;
               state_nx     = (LivesLeft == 2'd0) ? S_OVER : S_RACE;
            end else begin
               frame_cnt_nx = frame_cnt + 1'b1;
            end
         end
         S_FINISH, S_OVER: begin
            if (start) state_nx = S_IDLE;
         end
`ifdef PAUSE_EN
         S_PAUSE: begin
            if (p_edge) state_nx = S_RACE;
         end
`endif
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         state       <= S_IDLE;
         frame_cnt   <= '0;
         CountDigit  <= 3'd0;
         LivesLeft   <= 2'(LIVES_INIT);
         RaceTime    <= 16'd0;
         PlayerReset <= 1'b1;
         enter_q     <= 1'b0;
`ifdef PAUSE_EN
         p_q         <= 1'b0;
`endif
      end else begin
         state       <= state_nx;
         frame_cnt   <= frame_cnt_nx;
         CountDigit  <= digit_nx;
         LivesLeft   <= lives_nx;
         RaceTime    <= time_nx;
         // Registered from the next state so it changes on the same edge as GameState.
         PlayerReset <= (state_nx == S_IDLE) || (state_nx == S_COUNT);
         enter_q     <= enter_now;
`ifdef PAUSE_EN
         p_q         <= p_now;
`endif
      end
   end

   assign GameState = state;
   assign KeyOut_0  = (state == S_RACE) ? keycode_0 : 8'h00;
   assign KeyOut_1  = (state == S_RACE) ? keycode_1 : 8'h00;

endmodule

// File: tb/tb_race_sequencer.sv
// tb_race_sequencer
//   Directed bench for race_sequencer. Expected outputs are queued while the
//   stimulus is set up and compared after the following frame edge.
module tb_race_sequencer;

   logic        frame_clk;
   logic        Reset;
   logic [7:0]  keycode_0;
   logic [7:0]  keycode_1;
   logic        collision;
   logic [15:0] PlayerDistance;
   logic        PlayerReset;
   logic [7:0]  KeyOut_0;
   logic [7:0]  KeyOut_1;
   logic [2:0]  GameState;
   logic [2:0]  CountDigit;
   logic [1:0]  LivesLeft;
   logic [15:0] RaceTime;

   race_sequencer dut (
      .frame_clk      (frame_clk),
      .Reset          (Reset),
      .keycode_0      (keycode_0),
      .keycode_1      (keycode_1),
      .collision      (collision),
      .PlayerDistance (PlayerDistance),
      .PlayerReset    (PlayerReset),
      .KeyOut_0       (KeyOut_0),
      .KeyOut_1       (KeyOut_1),
      .GameState      (GameState),
      .CountDigit     (CountDigit),
      .LivesLeft      (LivesLeft),
      .RaceTime       (RaceTime)
   );

   initial frame_clk = 1'b0;
   always #5 frame_clk = ~frame_clk;

   localparam int SEL_STATE = 0;
   localparam int SEL_PRST  = 1;
   localparam int SEL_KO0   = 2;
   localparam int SEL_KO1   = 3;
   localparam int SEL_DIGIT = 4;
   localparam int SEL_LIVES = 5;
   localparam int SEL_TIME  = 6;

   typedef struct {
      string       tag;
      int          sel;
      logic [15:0] exp;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   exp_time    = 0;

   function automatic logic [15:0] observe(input int sel);
      case (sel)
         SEL_STATE: return {13'd0, GameState};
         SEL_PRST:  return {15'd0, PlayerReset};
         SEL_KO0:   return {8'd0, KeyOut_0};
         SEL_KO1:   return {8'd0, KeyOut_1};
         SEL_DIGIT: return {13'd0, CountDigit};
         SEL_LIVES: return {14'd0, LivesLeft};
         default:   return RaceTime;
      endcase
   endfunction

   task automatic exp_push(input string tag, input int sel, input int v);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = 16'(v);
      sb.push_back(e);
   endtask

   task automatic check_all();
      exp_t e;
      logic [15:0] obs;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = observe(e.sel);
         vectors++;
         assert (obs === e.exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h at %0t", e.tag, obs, e.exp, $time);
         end
      end
   endtask

   task automatic tick();
      @(posedge frame_clk);
      #1;
   endtask

   // Enter edge from IDLE, then the full countdown into RACE.
   task automatic start_to_race();
      keycode_0 = 8'h28;
      exp_push("count_entry_state", SEL_STATE, 1);
      exp_push("count_entry_digit", SEL_DIGIT, 3);
      exp_push("count_entry_lives", SEL_LIVES, 3);
      exp_push("count_entry_time", SEL_TIME, 0);
      exp_push("count_entry_prst", SEL_PRST, 1);
      tick();
      check_all();
      keycode_0 = 8'h00;
      for (int k = 1; k <= 180; k++) begin
         if (k < 180) begin
            exp_push("count_state", SEL_STATE, 1);
            exp_push("count_digit", SEL_DIGIT, 3 - k / 60);
            exp_push("count_prst", SEL_PRST, 1);
         end else begin
            exp_push("race_entry_state", SEL_STATE, 2);
            exp_push("race_entry_digit", SEL_DIGIT, 0);
            exp_push("race_entry_prst", SEL_PRST, 0);
            exp_push("race_entry_time", SEL_TIME, 0);
         end
         tick();
         check_all();
      end
      exp_time = 0;
   endtask

   // Collision in RACE, full lockout, then the state that follows it.
   task automatic crash_cycle(input int lives_after, input int final_state);
      collision = 1'b1;
      exp_time++;
      exp_push("crash_state", SEL_STATE, 3);
      exp_push("crash_lives", SEL_LIVES, lives_after);
      exp_push("crash_time", SEL_TIME, exp_time);
      tick();
      check_all();
      for (int j = 1; j <= 119; j++) begin
         // Collision stays high for a while to show it is ignored.
         if (j == 10) collision = 1'b0;
         exp_push("lockout_state", SEL_STATE, 3);
         exp_push("lockout_ko1", SEL_KO1, 0);
         exp_push("lockout_time", SEL_TIME, exp_time);
         exp_push("lockout_lives", SEL_LIVES, lives_after);
         tick();
         check_all();
      end
      exp_push("post_crash_state", SEL_STATE, final_state);
      exp_push("post_crash_time", SEL_TIME, exp_time);
      exp_push("post_crash_ko1", SEL_KO1, (final_state == 2) ? 8'h1A : 0);
      tick();
      check_all();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset          = 1'b1;
      keycode_0      = 8'h04;
      keycode_1      = 8'h00;
      collision      = 1'b0;
      PlayerDistance = 16'd0;
      tick();
      tick();
      exp_push("rst_state", SEL_STATE, 0);
      exp_push("rst_prst", SEL_PRST, 1);
      exp_push("rst_ko0", SEL_KO0, 0);
      exp_push("rst_lives", SEL_LIVES, 3);
      exp_push("rst_time", SEL_TIME, 0);
      exp_push("rst_digit", SEL_DIGIT, 0);
      check_all();

      Reset     = 1'b0;
      keycode_0 = 8'h00;
      exp_push("idle_state", SEL_STATE, 0);
      tick();
      check_all();

      start_to_race();

      // Key gating while racing.
      keycode_0 = 8'h07;
      keycode_1 = 8'h1A;
      #1;
      exp_push("race_ko0", SEL_KO0, 8'h07);
      exp_push("race_ko1", SEL_KO1, 8'h1A);
      check_all();
      for (int i = 1; i <= 10; i++) begin
         exp_time++;
         exp_push("race_time", SEL_TIME, exp_time);
         tick();
         check_all();
      end

      crash_cycle(2, 2);
      crash_cycle(1, 2);
      crash_cycle(0, 5);
      for (int i = 0; i < 3; i++) begin
         exp_push("over_state", SEL_STATE, 5);
         exp_push("over_lives", SEL_LIVES, 0);
         exp_push("over_time", SEL_TIME, exp_time);
         exp_push("over_prst", SEL_PRST, 0);
         exp_push("over_ko0", SEL_KO0, 0);
         tick();
         check_all();
      end

      // Start from OVER goes back to IDLE, which re-resets the car.
      keycode_0 = 8'h28;
      exp_push("over_to_idle_state", SEL_STATE, 0);
      exp_push("over_to_idle_prst", SEL_PRST, 1);
      tick();
      check_all();
      keycode_0 = 8'h00;
      tick();

      start_to_race();
      keycode_0 = 8'h00;

      // Finish and collision in the same frame: finish wins.
      PlayerDistance = 16'd20000;
      collision      = 1'b1;
      exp_time++;
      exp_push("finish_state", SEL_STATE, 4);
      exp_push("finish_lives", SEL_LIVES, 3);
      exp_push("finish_time", SEL_TIME, exp_time);
      exp_push("finish_prst", SEL_PRST, 0);
      tick();
      check_all();
      collision = 1'b0;
      for (int i = 0; i < 2; i++) begin
         exp_push("finish_hold_state", SEL_STATE, 4);
         exp_push("finish_hold_time", SEL_TIME, exp_time);
         tick();
         check_all();
      end

      // Enter held across FINISH: one IDLE transition, no restart.
      keycode_0 = 8'h28;
      exp_push("finish_to_idle", SEL_STATE, 0);
      tick();
      check_all();
      for (int i = 0; i < 5; i++) begin
         exp_push("held_enter_state", SEL_STATE, 0);
         exp_push("held_enter_prst", SEL_PRST, 1);
         tick();
         check_all();
      end
      keycode_0      = 8'h00;
      PlayerDistance = 16'd0;
      tick();

      // Reset in the middle of the countdown.
      keycode_0 = 8'h28;
      exp_push("restart_state", SEL_STATE, 1);
      tick();
      check_all();
      keycode_0 = 8'h00;
      for (int i = 0; i < 10; i++) tick();
      Reset = 1'b1;
      exp_push("midrst_state", SEL_STATE, 0);
      exp_push("midrst_digit", SEL_DIGIT, 0);
      exp_push("midrst_prst", SEL_PRST, 1);
      exp_push("midrst_time", SEL_TIME, 0);
      exp_push("midrst_lives", SEL_LIVES, 3);
      tick();
      check_all();
      Reset = 1'b0;
      tick();

      start_to_race();
      for (int i = 0; i < 5; i++) begin
         exp_time++;
         exp_push("pre_pause_time", SEL_TIME, exp_time);
         tick();
         check_all();
      end

`ifdef PAUSE_EN
      keycode_0 = 8'h13;
      exp_time++;
      exp_push("pause_state", SEL_STATE, 6);
      exp_push("pause_time", SEL_TIME, exp_time);
      exp_push("pause_ko0", SEL_KO0, 0);
      exp_push("pause_ko1", SEL_KO1, 0);
      exp_push("pause_prst", SEL_PRST, 0);
      tick();
      check_all();
      for (int i = 0; i < 3; i++) begin
         if (i == 1) collision = 1'b1;
         exp_push("pause_hold_state", SEL_STATE, 6);
         exp_push("pause_hold_time", SEL_TIME, exp_time);
         exp_push("pause_hold_lives", SEL_LIVES, 3);
         tick();
         check_all();
      end
      collision = 1'b0;
      keycode_0 = 8'h00;
      tick();
      keycode_0 = 8'h13;
      exp_push("unpause_state", SEL_STATE, 2);
      exp_push("unpause_time", SEL_TIME, exp_time);
      tick();
      check_all();
      keycode_0 = 8'h00;
      for (int i = 0; i < 2; i++) begin
         exp_time++;
         exp_push("resume_time", SEL_TIME, exp_time);
         exp_push("resume_state", SEL_STATE, 2);
         tick();
         check_all();
      end
`else
      keycode_0 = 8'h13;
      #1;
      exp_push("p_passthru_ko0", SEL_KO0, 8'h13);
      check_all();
      for (int i = 0; i < 3; i++) begin
         exp_time++;
         exp_push("p_nopause_state", SEL_STATE, 2);
         exp_push("p_nopause_time", SEL_TIME, exp_time);
         tick();
         check_all();
      end
      keycode_0 = 8'h00;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
